// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: byte FIFO fed by CPU stores, shifted out LSB first.
// Status word exposes busy, full, sticky overflow and FIFO fill level.
module uart_tx_mmio #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        begin_flag,
    input  logic [31:0] in_data,
    output logic [31:0] state_reg,
    output logic        tx
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]      DEPTH    = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] baud_cnt, baud_next;
    logic [2:0]       bit_idx, bit_next;
    logic [7:0]       shift, shift_next;
    logic             tx_next;
    logic             baud_last;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count, count_next;
    logic             overflow, overflow_next;
    logic             fifo_empty, fifo_full;
    logic             push_req, clear_req, push_ok, pop;
    logic [31:0]      state_reg_next;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH);
    assign push_req   = begin_flag & ~in_data[31];
    assign clear_req  = begin_flag & in_data[31];
    // A push into a full FIFO still fits when the transmitter pops the head in the same cycle.
    assign push_ok    = push_req & (~fifo_full | pop);
    assign baud_last  = (baud_cnt == CNT_LAST);

    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_idx;
        shift_next = shift;
        tx_next    = tx;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                    bit_next   = 3'd0;
                    baud_next  = '0;
                    state_next = START;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_next  = '0;
                    bit_next   = 3'd0;
                    state_next = DATA;
                    tx_next    = shift[0];
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_next = '0;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        shift_next = {1'b0, shift[7:1]};
                        tx_next    = shift[1];
                        bit_next   = bit_idx + 3'd1;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_next = '0;
                    // Chain straight into the next start bit so back-to-back frames have no gap.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr];
                        bit_next   = 3'd0;
                        state_next = START;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    always_comb begin
        count_next = count;
        case ({push_ok, pop})
            2'b10:   count_next = count + (AW + 1)'(1);
            2'b01:   count_next = count - (AW + 1)'(1);
            default: count_next = count;
        endcase
    end

    always_comb begin
        overflow_next = overflow;
        if (clear_req) begin
            overflow_next = 1'b0;
        end else if (push_req && !push_ok) begin
            overflow_next = 1'b1;
        end
    end

    always_comb begin
        state_reg_next      = '0;
        state_reg_next[0]   = (state_next != IDLE) | (count_next != '0);
        state_reg_next[1]   = (count_next == DEPTH);
        state_reg_next[2]   = overflow_next;
        state_reg_next[8:4] = 5'(count_next);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= 3'd0;
            shift     <= 8'd0;
            tx        <= 1'b1;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            state_reg <= '0;
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_next;
            bit_idx   <= bit_next;
            shift     <= shift_next;
            tx        <= tx_next;
            count     <= count_next;
            overflow  <= overflow_next;
            state_reg <= state_reg_next;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset_n && push_ok) begin
            mem[wr_ptr] <= in_data[7:0];
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: directed vector table, corner-case sequences and random traffic,
// every cycle compared against a frame-timeline reference model.
module tb_uart_tx_mmio;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic        clock;
    logic        reset_n;
    logic        begin_flag;
    logic [31:0] in_data;
    logic [31:0] state_reg;
    logic        tx;

    uart_tx_mmio #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .begin_flag(begin_flag),
        .in_data   (in_data),
        .state_reg (state_reg),
        .tx        (tx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queued bytes plus the position inside the frame being sent.
    logic [7:0] exp_q[$];
    logic       m_ovf     = 1'b0;
    logic       m_active  = 1'b0;
    logic [7:0] m_byte    = 8'd0;
    int         m_elapsed = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
        end
    endtask

    task automatic model_edge(input logic bf, input logic [31:0] d, input logic rst);
        int  pre_size;
        logic can_pop;
        if (rst) begin
            exp_q.delete();
            m_ovf     = 1'b0;
            m_active  = 1'b0;
            m_elapsed = 0;
            return;
        end
        pre_size = exp_q.size();
        can_pop  = (!m_active || m_elapsed == FRAME - 1) && pre_size > 0;
        if (m_active) begin
            m_elapsed++;
            if (m_elapsed == FRAME) m_active = 1'b0;
        end
        if (can_pop) begin
            m_byte    = exp_q.pop_front();
            m_active  = 1'b1;
            m_elapsed = 0;
        end
        if (bf && d[31]) begin
            m_ovf = 1'b0;
        end else if (bf) begin
            if (pre_size < DEPTH || can_pop) exp_q.push_back(d[7:0]);
            else m_ovf = 1'b1;
        end
    endtask

    function automatic logic model_tx();
        int k;
        if (!m_active) return 1'b1;
        k = m_elapsed / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_byte[k-1];
    endfunction

    function automatic logic [31:0] model_sr();
        logic [31:0] s;
        int n;
        n = exp_q.size();
        s = '0;
        s[0] = m_active || (n > 0);
        s[1] = (n == DEPTH);
        s[2] = m_ovf;
        s[8:4] = 5'(n);
        return s;
    endfunction

    task automatic step(input logic bf, input logic [31:0] d, input logic rst);
        begin_flag = bf;
        in_data    = d;
        reset_n    = ~rst;
        @(posedge clock);
        model_edge(bf, d, rst);
        #1;
        check("tx", {31'b0, tx}, {31'b0, model_tx()});
        check("state_reg", state_reg, model_sr());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((m_active || exp_q.size() > 0) && guard < 2000) begin
            step(1'b0, 32'h0, 1'b0);
            guard++;
        end
        n_checks++;
        if (guard >= 2000) begin
            n_fail++;
            $display("FAIL drain_timeout: got busy after %0d cycles expected idle", guard);
        end
        idle(2);
    endtask

    typedef struct {
        logic        bf;
        logic [31:0] data;
        logic        rst;
        int          reps;
        logic        exp_tx;
        logic [31:0] exp_sr;
    } vec_t;

    vec_t tbl[16];

    initial begin
        int guard;
        logic [31:0] d;

        begin_flag = 1'b0;
        in_data    = 32'h0;
        reset_n    = 1'b0;

        tbl[0]  = '{bf: 1'b0, data: 32'h0000_0000, rst: 1'b1, reps: 2, exp_tx: 1'b1, exp_sr: 32'h0};
        tbl[1]  = '{bf: 1'b1, data: 32'h0000_0055, rst: 1'b0, reps: 1, exp_tx: 1'b1, exp_sr: 32'h11};
        tbl[2]  = '{bf: 1'b0, data: 32'h0000_0000, rst: 1'b0, reps: 4, exp_tx: 1'b0, exp_sr: 32'h01};
        for (int b = 0; b < 8; b++)
            tbl[3+b] = '{bf: 1'b0, data: 32'h0, rst: 1'b0, reps: 4, exp_tx: (b % 2 == 0), exp_sr: 32'h01};
        tbl[11] = '{bf: 1'b0, data: 32'h0000_0000, rst: 1'b0, reps: 4, exp_tx: 1'b1, exp_sr: 32'h01};
        tbl[12] = '{bf: 1'b0, data: 32'h0000_0000, rst: 1'b0, reps: 3, exp_tx: 1'b1, exp_sr: 32'h00};
        tbl[13] = '{bf: 1'b1, data: 32'h8000_0000, rst: 1'b0, reps: 1, exp_tx: 1'b1, exp_sr: 32'h00};
        tbl[14] = '{bf: 1'b1, data: 32'h7FFF_FFA3, rst: 1'b0, reps: 1, exp_tx: 1'b1, exp_sr: 32'h11};
        tbl[15] = '{bf: 1'b0, data: 32'h0000_0000, rst: 1'b0, reps: 4, exp_tx: 1'b0, exp_sr: 32'h01};

        for (int i = 0; i < 16; i++) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                step((r == 0) ? tbl[i].bf : 1'b0, tbl[i].data, tbl[i].rst);
                check($sformatf("vec%0d_tx", i), {31'b0, tx}, {31'b0, tbl[i].exp_tx});
                check($sformatf("vec%0d_sr", i), state_reg, tbl[i].exp_sr);
            end
        end
        drain();

        // Back-to-back frames: second start bit right after the first stop bit.
        step(1'b1, 32'h0000_00A3, 1'b0);
        step(1'b1, 32'h0000_000F, 1'b0);
        check("b2b_count", {23'b0, state_reg[8:4]}, 32'd1);
        idle(FRAME - 1);
        check("b2b_stop", {31'b0, tx}, 32'd1);
        step(1'b0, 32'h0, 1'b0);
        check("b2b_start2", {31'b0, tx}, 32'd0);
        check("b2b_count0", {23'b0, state_reg[8:4]}, 32'd0);
        drain();

        // Six consecutive pushes: the sixth is dropped and overflow sticks until cleared.
        for (int i = 0; i < 6; i++) step(1'b1, 32'h0000_0011 + i, 1'b0);
        check("ovf_set", {31'b0, state_reg[2]}, 32'd1);
        check("ovf_full", {31'b0, state_reg[1]}, 32'd1);
        check("ovf_count", {23'b0, state_reg[8:4]}, 32'd4);
        step(1'b1, 32'h8000_0000, 1'b0);
        check("ovf_clear", {31'b0, state_reg[2]}, 32'd0);
        check("ovf_clear_count", {23'b0, state_reg[8:4]}, 32'd4);
        drain();

        // Reset during data bit 3, with a write strobe that must be ignored.
        step(1'b1, 32'h0000_00C6, 1'b0);
        idle(1 + 4 * CPB);
        step(1'b1, 32'h0000_0099, 1'b1);
        check("rst_tx", {31'b0, tx}, 32'd1);
        check("rst_sr", state_reg, 32'h0);
        step(1'b1, 32'h0000_003C, 1'b0);
        check("rst_repush", state_reg, 32'h11);
        drain();

        // Push into a full FIFO on the same edge the stop bit ends and pops the head.
        for (int i = 0; i < 5; i++) step(1'b1, 32'h0000_0070 + i, 1'b0);
        guard = 0;
        while (!(m_active && m_elapsed == FRAME - 1) && guard < 100) begin
            step(1'b0, 32'h0, 1'b0);
            guard++;
        end
        n_checks++;
        if (guard >= 100) begin
            n_fail++;
            $display("FAIL stop_sync_timeout: got no stop end after %0d cycles expected one", guard);
        end
        check("full_pre", {31'b0, state_reg[1]}, 32'd1);
        step(1'b1, 32'h0000_005A, 1'b0);
        check("fullpop_count", {23'b0, state_reg[8:4]}, 32'd4);
        check("fullpop_ovf", {31'b0, state_reg[2]}, 32'd0);
        check("fullpop_start", {31'b0, tx}, 32'd0);
        drain();

        // Random traffic against the reference model.
        for (int i = 0; i < 1500; i++) begin
            d = $urandom;
            d[31] = ($urandom_range(0, 7) == 0);
            step($urandom_range(0, 9) == 0, d, $urandom_range(0, 399) == 0);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
